// File: rtl/spsram_ctrl_if.sv
// Client-side channels of the single-port SRAM controller: write requests,
// read requests and read responses, each a valid/ready pair.
//   wr_vld/wr_a/wr_d -> wr_rdy   write request channel
//   rd_vld/rd_a      -> rd_rdy   read request channel
//   rsp_vld/rsp_d    <- rsp_rdy  read response channel
// master: client logic, slave: spsram_ctrl.
interface spsram_ctrl_if #(
   parameter int W  = 32,
   parameter int AW = 7
);
   logic          wr_vld;
   logic [AW-1:0] wr_a;
   logic [W-1:0]  wr_d;
   logic          wr_rdy;
   logic          rd_vld;
   logic [AW-1:0] rd_a;
   logic          rd_rdy;
   logic          rsp_vld;
   logic [W-1:0]  rsp_d;
   logic          rsp_rdy;

   modport master (
      output wr_vld, wr_a, wr_d, rd_vld, rd_a, rsp_rdy,
      input  wr_rdy, rd_rdy, rsp_vld, rsp_d
   );

   modport slave (
      input  wr_vld, wr_a, wr_d, rd_vld, rd_a, rsp_rdy,
      output wr_rdy, rd_rdy, rsp_vld, rsp_d
   );
endinterface

// File: rtl/spsram_ctrl.sv
// Initiator-side controller for the single-port SRAM macro. Arbitrates
// independent write and read requests onto the one macro port (one access
// per cycle), captures the macro's registered read data into a small
// response FIFO and presents it on a valid/ready response channel.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus             client channels (spsram_ctrl_if.slave)
//   sram_csn/wen/oen active-low macro controls, registered
//   sram_a, sram_di macro address and write data, registered
//   sram_dout       macro read data, valid the cycle after a read access
module spsram_ctrl #(
   parameter int W         = 32,
   parameter int N         = 128,
   parameter int RSP_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   spsram_ctrl_if.slave         bus,
   output logic                 sram_csn,
   output logic                 sram_wen,
   output logic                 sram_oen,
   output logic [$clog2(N)-1:0] sram_a,
   output logic [W-1:0]         sram_di,
   input  logic [W-1:0]         sram_dout
);
   localparam int AW = $clog2(N);
   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW = $clog2(RSP_DEPTH + 1);

   logic          last_wr;
   logic          rd_p1;
   logic          rd_p2;
   logic [CW-1:0] fifo_cnt;
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [W-1:0]  fifo_mem [RSP_DEPTH];
   logic          credit_ok;
   logic          gnt_wr;
   logic          gnt_rd;
   logic          rsp_vld;
   logic          push;
   logic          pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Every read already on the pins or on sram_dout owns a FIFO slot.
   // A same-cycle pop is ignored on purpose so the check stays registered-only.
   assign credit_ok = ({1'b0, fifo_cnt} + (CW+1)'(rd_p1) + (CW+1)'(rd_p2))
                      < (CW+1)'(RSP_DEPTH);

   // Grants are held off while in reset so both ready outputs read 0.
   always_comb begin
      gnt_wr = 1'b0;
      gnt_rd = 1'b0;
      if (rst_n) begin
         if (bus.wr_vld && bus.rd_vld && credit_ok) begin
            // Same-address collision: write first, read then returns new data.
            if ((bus.wr_a == bus.rd_a) || !last_wr) gnt_wr = 1'b1;
            else                                    gnt_rd = 1'b1;
         end else if (bus.wr_vld) begin
            gnt_wr = 1'b1;
         end else if (bus.rd_vld && credit_ok) begin
            gnt_rd = 1'b1;
         end
      end
   end

   assign bus.wr_rdy = gnt_wr;
   assign bus.rd_rdy = gnt_rd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sram_csn <= 1'b1;
         sram_wen <= 1'b1;
         sram_oen <= 1'b1;
         sram_a   <= '0;
         sram_di  <= '0;
         rd_p1    <= 1'b0;
         rd_p2    <= 1'b0;
         last_wr  <= 1'b0;
      end else begin
         rd_p1 <= gnt_rd;
         rd_p2 <= rd_p1;
         if (gnt_wr) begin
            sram_csn <= 1'b0;
            sram_wen <= 1'b0;
            sram_oen <= 1'b1;
            sram_a   <= bus.wr_a;
            sram_di  <= bus.wr_d;
            last_wr  <= 1'b1;
         end else if (gnt_rd) begin
            sram_csn <= 1'b0;
            sram_wen <= 1'b1;
            sram_oen <= 1'b0;
            sram_a   <= bus.rd_a;
            sram_di  <= '0;
            last_wr  <= 1'b0;
         end else begin
            sram_csn <= 1'b1;
            sram_wen <= 1'b1;
            sram_oen <= 1'b1;
            sram_a   <= '0;
            sram_di  <= '0;
         end
      end
   end

   // sram_dout is only looked at when rd_p2 says it carries read data.
   assign push    = rd_p2;
   assign rsp_vld = (fifo_cnt != '0);
   assign pop     = rsp_vld & bus.rsp_rdy;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wptr] <= sram_dout;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_cnt <= '0;
         wptr     <= '0;
         rptr     <= '0;
      end else begin
         if (push) wptr <= ptr_inc(wptr);
         if (pop)  rptr <= ptr_inc(rptr);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   assign bus.rsp_vld = rsp_vld;
   // Zero when empty keeps uninitialised FIFO storage off the response bus.
   assign bus.rsp_d   = rsp_vld ? fifo_mem[rptr] : '0;
endmodule

// File: tb/tb_spsram_ctrl.sv
module tb_spsram_ctrl;
   localparam int W  = 32;
   localparam int N  = 128;
   localparam int AW = 7;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          sram_csn, sram_wen, sram_oen;
   logic [AW-1:0] sram_a;
   logic [W-1:0]  sram_di;
   logic [W-1:0]  sram_dout;

   spsram_ctrl_if #(.W(W), .AW(AW)) bus ();

   spsram_ctrl #(.W(W), .N(N), .RSP_DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .sram_csn  (sram_csn),
      .sram_wen  (sram_wen),
      .sram_oen  (sram_oen),
      .sram_a    (sram_a),
      .sram_di   (sram_di),
      .sram_dout (sram_dout)
   );

   always #5 clk = ~clk;

   int           checks   = 0;
   int           failures = 0;
   logic [W-1:0] smem    [N];
   logic [W-1:0] ref_mem [N];
   logic [W-1:0] exp_q   [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Behavioural macro: registered read data, write at end of access cycle.
   always @(posedge clk) begin
      if (!sram_csn && !sram_wen) smem[sram_a] <= sram_di;
      if (!sram_csn && sram_wen && !sram_oen) sram_dout <= smem[sram_a];
      else                                    sram_dout <= 'x;
   end

   // Scoreboard: reference memory updated in grant order, expected data
   // queued on read grant, compared on response handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         check("rdy_exclusive", 64'(bus.wr_rdy & bus.rd_rdy), 64'd0);
         if (bus.wr_vld && bus.wr_rdy) ref_mem[bus.wr_a] = bus.wr_d;
         if (bus.rd_vld && bus.rd_rdy) exp_q.push_back(ref_mem[bus.rd_a]);
         if (bus.rsp_vld && bus.rsp_rdy) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rsp_unexpected actual=0x%0h required=none", bus.rsp_d);
            end else begin
               check("rsp_d", 64'(bus.rsp_d), 64'(exp_q.pop_front()));
            end
         end
      end
   end

   typedef struct {
      logic          wv;
      logic [AW-1:0] wa;
      logic [W-1:0]  wd;
      logic          rv;
      logic [AW-1:0] ra;
      logic          ewr;
      logic          erd;
   } vec_t;

   vec_t tbl [12];

   task automatic idle_inputs();
      bus.wr_vld = 1'b0;
      bus.wr_a   = '0;
      bus.wr_d   = '0;
      bus.rd_vld = 1'b0;
      bus.rd_a   = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      next_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int issued, wgr, ok, g, rdy_cnt, last_g, n_rsp, first_c, last_c;

      for (int i = 0; i < N; i++) begin
         smem[i]    <= 32'hC0DE_0000 | W'(i);
         ref_mem[i] = 32'hC0DE_0000 | W'(i);
      end
      idle_inputs();
      bus.rsp_rdy = 1'b1;

      // Reset values, with requests asserted to show ready stays low.
      #1 rst_n = 1'b0;
      bus.wr_vld = 1'b1;
      bus.rd_vld = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_wr_rdy",  64'(bus.wr_rdy),  64'd0);
      check("rst_rd_rdy",  64'(bus.rd_rdy),  64'd0);
      check("rst_rsp_vld", 64'(bus.rsp_vld), 64'd0);
      check("rst_rsp_d",   64'(bus.rsp_d),   64'd0);
      check("rst_csn",     64'(sram_csn),    64'd1);
      check("rst_wen",     64'(sram_wen),    64'd1);
      check("rst_oen",     64'(sram_oen),    64'd1);
      check("rst_a",       64'(sram_a),      64'd0);
      check("rst_di",      64'(sram_di),     64'd0);
      idle_inputs();
      #2 rst_n = 1'b1;
      next_cycle();

      // Write 5 then read 5: 3-cycle read latency.
      bus.wr_vld = 1'b1; bus.wr_a = 7'd5; bus.wr_d = 32'hDEAD_BEEF;
      @(negedge clk);
      check("t1_wr_rdy", 64'(bus.wr_rdy), 64'd1);
      next_cycle();
      bus.wr_vld = 1'b0; bus.rd_vld = 1'b1; bus.rd_a = 7'd5;
      @(negedge clk);
      check("t1_wpin_csn", 64'(sram_csn), 64'd0);
      check("t1_wpin_wen", 64'(sram_wen), 64'd0);
      check("t1_wpin_oen", 64'(sram_oen), 64'd1);
      check("t1_wpin_a",   64'(sram_a),   64'd5);
      check("t1_wpin_di",  64'(sram_di),  64'hDEAD_BEEF);
      check("t1_rd_rdy",   64'(bus.rd_rdy), 64'd1);
      next_cycle();
      bus.rd_vld = 1'b0;
      @(negedge clk);
      check("t1_rpin_csn", 64'(sram_csn), 64'd0);
      check("t1_rpin_wen", 64'(sram_wen), 64'd1);
      check("t1_rpin_oen", 64'(sram_oen), 64'd0);
      check("t1_rpin_a",   64'(sram_a),   64'd5);
      check("t1_rsp_vld_g1", 64'(bus.rsp_vld), 64'd0);
      next_cycle();
      @(negedge clk);
      check("t1_rsp_vld_g2", 64'(bus.rsp_vld), 64'd0);
      next_cycle();
      @(negedge clk);
      check("t1_rsp_vld_g3", 64'(bus.rsp_vld), 64'd1);
      check("t1_rsp_d_g3",   64'(bus.rsp_d),   64'hDEAD_BEEF);
      next_cycle();

      // Arbitration table, starting from reset (last_wr=0).
      do_reset();
      tbl[0]  = '{1'b1, 7'd1,  32'h0000_0011, 1'b1, 7'd2,  1'b1, 1'b0};
      tbl[1]  = '{1'b1, 7'd3,  32'h0000_0033, 1'b1, 7'd2,  1'b0, 1'b1};
      tbl[2]  = '{1'b1, 7'd3,  32'h0000_0033, 1'b1, 7'd4,  1'b1, 1'b0};
      tbl[3]  = '{1'b1, 7'd5,  32'h0000_0055, 1'b1, 7'd4,  1'b0, 1'b1};
      tbl[4]  = '{1'b0, 7'd0,  32'h0000_0000, 1'b1, 7'd6,  1'b0, 1'b1};
      tbl[5]  = '{1'b1, 7'd7,  32'h0000_0077, 1'b0, 7'd0,  1'b1, 1'b0};
      tbl[6]  = '{1'b1, 7'd8,  32'h0000_0088, 1'b0, 7'd0,  1'b1, 1'b0};
      tbl[7]  = '{1'b1, 7'd10, 32'h0000_00AA, 1'b1, 7'd11, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 7'd12, 32'h0000_0C01, 1'b1, 7'd12, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 7'd12, 32'h0000_0C02, 1'b1, 7'd12, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 7'd13, 32'h0000_00DD, 1'b1, 7'd12, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 7'd0,  32'h0000_0000, 1'b0, 7'd0,  1'b0, 1'b0};
      for (int i = 0; i < 12; i++) begin
         bus.wr_vld = tbl[i].wv; bus.wr_a = tbl[i].wa; bus.wr_d = tbl[i].wd;
         bus.rd_vld = tbl[i].rv; bus.rd_a = tbl[i].ra;
         @(negedge clk);
         check($sformatf("tbl_wr_rdy[%0d]", i), 64'(bus.wr_rdy), 64'(tbl[i].ewr));
         check($sformatf("tbl_rd_rdy[%0d]", i), 64'(bus.rd_rdy), 64'(tbl[i].erd));
         next_cycle();
      end
      idle_inputs();
      repeat (5) next_cycle();

      // Same-address collision after a write (last_wr=1): write still wins.
      bus.wr_vld = 1'b1; bus.wr_a = 7'd9; bus.wr_d = 32'h1;
      next_cycle();
      bus.wr_d = 32'h2; bus.rd_vld = 1'b1; bus.rd_a = 7'd9;
      @(negedge clk);
      check("same_a_wr_rdy", 64'(bus.wr_rdy), 64'd1);
      check("same_a_rd_rdy", 64'(bus.rd_rdy), 64'd0);
      next_cycle();
      bus.wr_vld = 1'b0;
      @(negedge clk);
      check("same_a_rd_rdy2", 64'(bus.rd_rdy), 64'd1);
      next_cycle();
      bus.rd_vld = 1'b0;
      ok = 0;
      for (int c = 0; c < 20 && ok == 0; c++) begin
         @(negedge clk);
         if (bus.rsp_vld) begin
            ok = 1;
            check("same_a_rsp_d", 64'(bus.rsp_d), 64'h2);
         end
         next_cycle();
      end
      if (ok == 0) check("same_a_rsp_timeout", 64'd0, 64'd1);
      repeat (3) next_cycle();

      // Credit stall with rsp_rdy=0: 4 reads, then writes still granted.
      bus.rsp_rdy = 1'b0;
      issued = 0;
      wgr = 0;
      for (int c = 0; c < 12; c++) begin
         bus.rd_vld = 1'b1;
         bus.rd_a   = AW'(16 + issued);
         bus.wr_vld = (c >= 8);
         bus.wr_a   = AW'(100 + c);
         bus.wr_d   = 32'h5A00_0000 | W'(c);
         @(negedge clk);
         if (bus.rd_rdy) issued++;
         if (bus.wr_rdy) wgr++;
         next_cycle();
      end
      check("stall_reads_granted", 64'(issued), 64'd4);
      check("stall_writes_granted", 64'(wgr), 64'd4);
      bus.wr_vld  = 1'b0;
      bus.rsp_rdy = 1'b1;
      ok = 0;
      for (int c = 0; c < 100 && ok == 0; c++) begin
         bus.rd_vld = (issued < 8);
         bus.rd_a   = AW'(16 + issued);
         @(negedge clk);
         if (bus.rd_vld && bus.rd_rdy) issued++;
         next_cycle();
         if (issued == 8 && exp_q.size() == 0) ok = 1;
      end
      check("stall_drain_done", 64'(ok), 64'd1);
      idle_inputs();
      repeat (3) next_cycle();

      // Streaming reads 0..15 with rsp_rdy=1.
      g = 0; rdy_cnt = 0; last_g = -1; n_rsp = 0; first_c = -1; last_c = -1;
      for (int c = 0; c < 24; c++) begin
         bus.rd_vld = (g < 16);
         bus.rd_a   = AW'(g);
         @(negedge clk);
         if (bus.rd_vld && bus.rd_rdy) begin
            rdy_cnt++;
            last_g = c;
            g++;
         end
         if (bus.rsp_vld) begin
            n_rsp++;
            if (first_c < 0) first_c = c;
            last_c = c;
         end
         next_cycle();
      end
      check("stream_grants", 64'(rdy_cnt), 64'd16);
      check("stream_last_grant_cycle", 64'(last_g), 64'd15);
      check("stream_rsp_count", 64'(n_rsp), 64'd16);
      check("stream_rsp_span", 64'(last_c - first_c), 64'd15);
      check("stream_first_rsp_cycle", 64'(first_c), 64'd3);
      idle_inputs();
      repeat (3) next_cycle();

      // Reset with two reads in flight and one FIFO entry.
      bus.rsp_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.rd_vld = 1'b1;
         bus.rd_a   = AW'(40 + k);
         @(negedge clk);
         check($sformatf("inflight_rd_rdy[%0d]", k), 64'(bus.rd_rdy), 64'd1);
         next_cycle();
      end
      bus.rd_vld = 1'b0;
      #2;
      check("pre_rst_csn", 64'(sram_csn), 64'd0);
      check("pre_rst_rsp_vld", 64'(bus.rsp_vld), 64'd1);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("async_rst_csn", 64'(sram_csn), 64'd1);
      check("async_rst_oen", 64'(sram_oen), 64'd1);
      check("async_rst_a", 64'(sram_a), 64'd0);
      check("async_rst_rsp_vld", 64'(bus.rsp_vld), 64'd0);
      check("async_rst_rsp_d", 64'(bus.rsp_d), 64'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      bus.rsp_rdy = 1'b1;
      n_rsp = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.rsp_vld) n_rsp++;
      end
      check("post_rst_no_stale_rsp", 64'(n_rsp), 64'd0);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
